ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send-side partner of the keyboard receiver (ps2_rx).

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_clk_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, defaults and helpers
// Purpose: state encoding and default timing for the PS/2 host transmitter.
// Contents: ps2_state_t, timing defaults, counter widths, odd_parity().
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP
  } ps2_state_t;

  localparam int INHIBIT_DEFAULT = 5000;
  localparam int FILTER_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 750000;

  localparam int CNT_W  = 13;
  localparam int WDOG_W = 20;
  localparam int N_W    = 4;

  // Parity bit that makes the total number of ones in {parity, d} odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 line synchroniser, clock glitch filter, fall strobe
// Purpose: condition the raw PS/2 clock and data lines for the host/device state machines.
// Ports:
//   CLOCK_50    in   system clock
//   frame_reset in   asynchronous active-high reset
//   ps2c_in     in   raw PS2_KBCLK level
//   ps2d_in     in   raw PS2_KBDAT level
//   ps2d_sync   out  2-FF synchronised data level
//   fall_tick   out  one-cycle strobe on filtered clock 1->0
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLOCK_50,
  input  logic frame_reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2d_sync,
  output logic fall_tick
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] c_hist;
  logic                  c_filt;
  logic                  c_filt_next;

  // Filtered clock only moves once every sample in the window agrees.
  always_comb begin
    c_filt_next = c_filt;
    if (&c_hist)
      c_filt_next = 1'b1;
    else if (~|c_hist)
      c_filt_next = 1'b0;
  end

  // Idle-high reset values keep a reset from looking like a clock edge.
  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      c_hist    <= '1;
      c_filt    <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c_in};
      d_sync    <= {d_sync[0], ps2d_in};
      c_hist    <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
      c_filt    <= c_filt_next;
      fall_tick <= c_filt & ~c_filt_next;
    end
  end

  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Purpose: send one command byte to a PS/2 device (inhibit, start, 8 data LSB first,
//   odd parity, stop, ACK check) over open-drain clock/data lines.
// Ports:
//   CLOCK_50     in   system clock, 50 MHz
//   frame_reset  in   asynchronous active-high reset
//   wr_ps2       in   one-cycle send request, accepted only when tx_idle=1
//   din[7:0]     in   command byte, sampled on the accepted request
//   ps2c_in      in   raw PS2_KBCLK level
//   ps2d_in      in   raw PS2_KBDAT level
//   ps2c_oe      out  1 = pull PS2_KBCLK low
//   ps2d_oe      out  1 = pull PS2_KBDAT low
//   tx_idle      out  1 while idle (gates the receiver)
//   tx_done_tick out  one-cycle pulse: frame sent and ACKed
//   tx_err       out  one-cycle pulse: NACK or device clock timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_DEFAULT,
  parameter int FILTER_LEN     = FILTER_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       frame_reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WDOG_W-1:0] wdog, wdog_n;
  logic [N_W-1:0]    n, n_n;
  logic [8:0]        shreg, shreg_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              fall;
  logic              ps2d_s;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .CLOCK_50   (CLOCK_50),
    .frame_reset(frame_reset),
    .ps2c_in    (ps2c_in),
    .ps2d_in    (ps2d_in),
    .ps2d_sync  (ps2d_s),
    .fall_tick  (fall)
  );

  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wdog   <= '0;
      n      <= '0;
      shreg  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wdog   <= wdog_n;
      n      <= n_n;
      shreg  <= shreg_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wdog_n  = wdog;
    n_n     = n;
    shreg_n = shreg;
    done_n  = 1'b0;
    err_n   = 1'b0;

    // Watchdog covers every phase clocked by the device; a fall always
    // reloads it, so a fall on the expiry cycle wins over the timeout.
    if (state == START || state == DATA || state == STOP) begin
      if (fall) begin
        wdog_n = '0;
      end else if (wdog == WDOG_MAX) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end else begin
        wdog_n = wdog + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (wr_ps2) begin
          shreg_n = {odd_parity(din), din};
          cnt_n   = CNT_LOAD;
          state_n = RTS;
        end
      end
      RTS: begin
        if (cnt == '0) begin
          wdog_n  = '0;
          state_n = START;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      START: begin
        if (fall) begin
          n_n     = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          if (n == N_W'(8)) begin
            state_n = STOP;
          end else begin
            shreg_n = {1'b0, shreg[8:1]};
            n_n     = n + 1'b1;
          end
        end
      end
      STOP: begin
        if (fall) begin
          // Device pulls data low on the final clock to acknowledge.
          done_n  = ~ps2d_s;
          err_n   = ps2d_s;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line drives are decoded from state so an async reset releases them at once.
  assign ps2c_oe      = (state == RTS);
  assign ps2d_oe      = (state == START) || ((state == DATA) && ~shreg[0]);
  assign tx_idle      = (state == IDLE);
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int FILT = 8;
  localparam int TMO  = 1500;

  logic       CLOCK_50 = 1'b0;
  logic       frame_reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic glitch  = 1'b0;
  logic bus_c, bus_d;

  assign bus_c   = dev_clk & ~ps2c_oe;
  assign bus_d   = dev_dat & ~ps2d_oe;
  assign ps2c_in = bus_c & ~glitch;
  assign ps2d_in = bus_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .frame_reset (frame_reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rts_len = 0;
  int done_base, err_base, rts_base;
  logic [9:0] dev_bits;
  bit dev_ok;

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (tx_done_tick) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done_tick && tx_err) both_cnt++;
    if (ps2c_oe) rts_len++;
  end

  initial begin
    repeat (95000) @(posedge CLOCK_50);
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge CLOCK_50);
    frame_reset = 1'b1;
    @(negedge CLOCK_50);
    frame_reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    done_base = done_cnt;
    err_base  = err_cnt;
    rts_base  = rts_len;
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge CLOCK_50);
    wr_ps2 = 1'b0;
  endtask

  // Device side: wait for request-to-send, then clock up to max_falls pulses,
  // reading the data line just before each rising edge and ACKing on pulse 11.
  task automatic device_run(input int half, input bit nack, input int glitch_pulse,
                            input int max_falls, output logic [9:0] bits, output bit ok);
    int k;
    ok = 0;
    bits = '0;
    k = 0;
    while (!(bus_c && !bus_d) && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (k >= 5000) return;
    repeat (20) @(negedge CLOCK_50);
    for (int i = 0; i < 11; i++) begin
      if (i == max_falls) break;
      if (i == 10) dev_dat = nack;
      dev_clk = 1'b0;
      repeat (half) @(negedge CLOCK_50);
      if (i < 10) bits[i] = bus_d;
      dev_clk = 1'b1;
      if (i == glitch_pulse) begin
        repeat (half / 2) @(negedge CLOCK_50);
        glitch = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        glitch = 1'b0;
        repeat (half - half / 2 - 3) @(negedge CLOCK_50);
      end else begin
        repeat (half) @(negedge CLOCK_50);
      end
      if (i == 10) dev_dat = 1'b1;
    end
    ok = 1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input int half,
                          input bit nack, input int glitch_pulse, input bit second_wr);
    logic [9:0] exp;
    int k;
    exp = frame_bits(b);
    start_tx(b);
    fork
      device_run(half, nack, glitch_pulse, 11, dev_bits, dev_ok);
      if (second_wr) begin
        repeat (30) @(negedge CLOCK_50);
        wr_ps2 = 1'b1;
        din    = 8'h00;
        @(negedge CLOCK_50);
        wr_ps2 = 1'b0;
      end
    join
    k = 0;
    while (!tx_idle && k < 2000) begin
      @(negedge CLOCK_50);
      k++;
    end
    repeat (20) @(negedge CLOCK_50);
    check_eq({tag, "_dev_started"}, 32'(dev_ok), 32'd1);
    check_eq({tag, "_rts_len"}, 32'(rts_len - rts_base), 32'(INH));
    check_eq({tag, "_bits"}, 32'(dev_bits), 32'(exp));
    check_eq({tag, "_done"}, 32'(done_cnt - done_base), nack ? 32'd0 : 32'd1);
    check_eq({tag, "_err"}, 32'(err_cnt - err_base), nack ? 32'd1 : 32'd0);
    check_eq({tag, "_idle"}, 32'(tx_idle), 32'd1);
    check_eq({tag, "_oe"}, {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int k, t0, t1;

    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check_eq("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check_eq("rst_tx_idle", 32'(tx_idle), 32'd1);
    check_eq("rst_done_err", {30'd0, tx_done_tick, tx_err}, 32'd0);
    frame_reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    // ACKed frames: the classic set-LEDs byte, then random bytes and clock rates.
    do_frame("ack_ed", 8'hED, 40, 1'b0, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      do_frame($sformatf("ack_rand%0d", i), b, $urandom_range(30, 80), 1'b0, -1, 1'b0);
    end

    // NACKed frames.
    do_frame("nack_01", 8'h01, 40, 1'b1, -1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      do_frame($sformatf("nack_rand%0d", i), b, $urandom_range(30, 80), 1'b1, -1, 1'b0);
    end

    // Short low glitch on the device clock while data bits are moving.
    do_frame("glitch_ed", 8'hED, 50, 1'b0, 4, 1'b0);

    // Request while busy must be dropped.
    b = 8'($urandom) | 8'h01;
    do_frame("busy_wr", b, 40, 1'b0, -1, 1'b1);

    // Device never clocks: timeout measured from first START cycle.
    start_tx(8'hFF);
    k = 0;
    while (ps2c_oe && k < 1000) begin
      @(negedge CLOCK_50);
      k++;
    end
    t0 = cyc;
    check_eq("tmo_start_d", 32'(ps2d_oe), 32'd1);
    k = 0;
    while (!tx_err && k < 3000) begin
      @(negedge CLOCK_50);
      k++;
    end
    t1 = cyc;
    check_eq("tmo_latency", 32'(t1 - t0), 32'(TMO));
    @(negedge CLOCK_50);
    check_eq("tmo_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    check_eq("tmo_idle", 32'(tx_idle), 32'd1);
    check_eq("tmo_err", 32'(err_cnt - err_base), 32'd1);
    check_eq("tmo_done", 32'(done_cnt - done_base), 32'd0);

    // Async reset mid-frame, while data bit d4 (forced 0) is being driven.
    b = 8'($urandom) & 8'hEF;
    start_tx(b);
    device_run(40, 1'b0, -1, 5, dev_bits, dev_ok);
    check_eq("abort_dev_started", 32'(dev_ok), 32'd1);
    check_eq("abort_pre_d_oe", 32'(ps2d_oe), 32'd1);
    check_eq("abort_pre_busy", 32'(tx_idle), 32'd0);
    #3;
    frame_reset = 1'b1;
    #1;
    check_eq("abort_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    check_eq("abort_idle", 32'(tx_idle), 32'd1);
    @(negedge CLOCK_50);
    frame_reset = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    check_eq("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    check_eq("abort_no_err", 32'(err_cnt - err_base), 32'd0);

    check_eq("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
